// File: rtl/vblank_update_arbiter_pkg.sv
// Shared video timing constants and arbiter FSM encodings for the vblank
// update arbiter and its round-robin selector.
package vblank_update_arbiter_pkg;

  // Line/frame geometry shared with videosyncs
  localparam int VGA_HTOTAL  = 800;
  localparam int VGA_VTOTAL  = 525;
  localparam int VGA_HACTIVE = 640;
  localparam int VGA_VACTIVE = 480;

  // Arbiter defaults
  localparam int ARB_NREQ    = 4;
  localparam int ARB_GUARD   = 32;
  localparam int ARB_MAXHOLD = 4096;

  // Port widths fixed by the videosyncs interface and the 8-requester ceiling
  localparam int CNT_W    = 10;
  localparam int GNT_ID_W = 3;

  typedef enum logic [1:0] {
    ST_CLOSED = 2'd0,
    ST_IDLE   = 2'd1,
    ST_GRANT  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/vblank_update_arbiter_rr_pick.sv
// Combinational round-robin selector: starting just after the last winner,
// returns the first asserted request as one-hot plus its index.
module vblank_update_arbiter_rr_pick
  import vblank_update_arbiter_pkg::*;
#(
  parameter int NREQ = ARB_NREQ
) (
  input  logic [NREQ-1:0]     req,
  input  logic [GNT_ID_W-1:0] ptr,
  output logic [NREQ-1:0]     pick,
  output logic [GNT_ID_W-1:0] id,
  output logic                any
);

  logic [3:0]        start;
  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [3:0]        first;
  logic [3:0]        sum;
  logic [3:0]        win;

  // Rotate requests so the slot after ptr sits at bit 0, find the lowest set bit, rotate back
  always_comb begin
    start = (({1'b0, ptr} + 4'd1) >= 4'(NREQ)) ? 4'd0 : ({1'b0, ptr} + 4'd1);
    dbl   = {req, req};
    rot   = NREQ'(dbl >> start);
    first = 4'd0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) first = 4'(i);
    end
    sum  = start + first;
    win  = (sum >= 4'(NREQ)) ? (sum - 4'(NREQ)) : sum;
    any  = |req;
    pick = any ? (NREQ'(1) << win) : '0;
    id   = any ? win[2:0] : '0;
  end

endmodule

// File: rtl/vblank_update_arbiter.sv
// Grants vertical-blanking access to one game-logic requester at a time,
// round-robin, only while the blanking window is open. Watches the
// videosyncs hc/vc counters and emits a per-frame tick.
module vblank_update_arbiter
  import vblank_update_arbiter_pkg::*;
#(
  parameter int NREQ    = ARB_NREQ,
  parameter int HTOTAL  = VGA_HTOTAL,
  parameter int VTOTAL  = VGA_VTOTAL,
  parameter int VACTIVE = VGA_VACTIVE,
  parameter int GUARD   = ARB_GUARD,
  parameter int MAXHOLD = ARB_MAXHOLD
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CNT_W-1:0]    hc,
  input  logic [CNT_W-1:0]    vc,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ-1:0]     done,
  output logic [NREQ-1:0]     gnt,
  output logic [GNT_ID_W-1:0] gnt_id,
  output logic                window_open,
  output logic                frame_tick,
  output logic                timeout,
  output logic                overrun
);

  localparam int                 HOLD_W    = $clog2(MAXHOLD);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(MAXHOLD - 1);
  localparam logic [CNT_W-1:0]   V_OPEN    = CNT_W'(VACTIVE);
  localparam logic [CNT_W-1:0]   V_CLOSE   = CNT_W'(VTOTAL - 1);
  localparam logic [CNT_W-1:0]   H_CLOSE   = CNT_W'(HTOTAL - GUARD - 1);

  if (!(VACTIVE < VTOTAL - 1)) begin : g_bad_vactive
    $error("vblank_update_arbiter: VACTIVE must be below VTOTAL-1");
  end
  if (!(GUARD < HTOTAL)) begin : g_bad_guard
    $error("vblank_update_arbiter: GUARD must be below HTOTAL");
  end
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("vblank_update_arbiter: NREQ must be 2..8");
  end
  if (MAXHOLD < 2) begin : g_bad_maxhold
    $error("vblank_update_arbiter: MAXHOLD must be at least 2");
  end
  if (HTOTAL > 1024 || VTOTAL > 1024) begin : g_bad_counts
    $error("vblank_update_arbiter: HTOTAL/VTOTAL must fit the 10-bit counters");
  end

  arb_state_e          state, state_d;
  logic [GNT_ID_W-1:0] ptr, ptr_d;
  logic [HOLD_W-1:0]   hold, hold_d;
  logic [NREQ-1:0]     gnt_d;
  logic [GNT_ID_W-1:0] gnt_id_d;
  logic                win_d, tick_d, to_d, ov_d;

  logic                ev_open, ev_close, ev_tick;
  logic                cur_done, cur_req, hold_last, release_req;
  logic [NREQ-1:0]     pick;
  logic [GNT_ID_W-1:0] pick_id;
  logic                pick_any;

  // Counter values outside 0..TOTAL-1 simply never compare equal
  assign ev_open  = (hc == '0) && (vc == V_OPEN);
  assign ev_close = (vc == V_CLOSE) && (hc == H_CLOSE);
  assign ev_tick  = (hc == '0) && (vc == '0);

  // gnt is one-hot, so masking isolates the granted requester's bits
  assign cur_done    = |(done & gnt);
  assign cur_req     = |(req & gnt);
  assign hold_last   = (hold == HOLD_LAST);
  assign release_req = cur_done || !cur_req;

  vblank_update_arbiter_rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .req  (req),
    .ptr  (ptr),
    .pick (pick),
    .id   (pick_id),
    .any  (pick_any)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_CLOSED;
    else        state <= state_d;
  end

  // Next-state: window open/close events plus grant entry and release
  always_comb begin
    state_d = state;
    unique case (state)
      ST_CLOSED: if (ev_open) state_d = ST_IDLE;
      ST_IDLE: begin
        if (ev_close)      state_d = ST_CLOSED;
        else if (pick_any) state_d = ST_GRANT;
      end
      ST_GRANT: begin
        if (ev_close)                      state_d = ST_CLOSED;
        else if (release_req || hold_last) state_d = ST_IDLE;
      end
      default: state_d = ST_CLOSED;
    endcase
  end

  // Next values for grant, pointer, hold counter and status pulses
  always_comb begin
    gnt_d    = gnt;
    gnt_id_d = gnt_id;
    ptr_d    = ptr;
    hold_d   = hold;
    to_d     = 1'b0;
    ov_d     = 1'b0;
    tick_d   = ev_tick;
    win_d    = (state_d != ST_CLOSED);
    unique case (state)
      ST_IDLE: begin
        if (!ev_close && pick_any) begin
          gnt_d    = pick;
          gnt_id_d = pick_id;
          ptr_d    = pick_id;
          hold_d   = '0;
        end else begin
          gnt_d    = '0;
          gnt_id_d = '0;
        end
      end
      ST_GRANT: begin
        if (ev_close) begin
          gnt_d    = '0;
          gnt_id_d = '0;
          ov_d     = 1'b1;
        end else if (release_req) begin
          gnt_d    = '0;
          gnt_id_d = '0;
        end else if (hold_last) begin
          gnt_d    = '0;
          gnt_id_d = '0;
          to_d     = 1'b1;
        end else begin
          hold_d = (hold == '1) ? hold : hold + 1'b1;
        end
      end
      default: begin
        gnt_d    = '0;
        gnt_id_d = '0;
      end
    endcase
  end

  // Output and datapath registers; reset drops any grant immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt         <= '0;
      gnt_id      <= '0;
      ptr         <= GNT_ID_W'(NREQ - 1);
      hold        <= '0;
      window_open <= 1'b0;
      frame_tick  <= 1'b0;
      timeout     <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      gnt         <= gnt_d;
      gnt_id      <= gnt_id_d;
      ptr         <= ptr_d;
      hold        <= hold_d;
      window_open <= win_d;
      frame_tick  <= tick_d;
      timeout     <= to_d;
      overrun     <= ov_d;
    end
  end

endmodule
